// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART transmit path.
//   BYTE_WIDTH      : default data byte width
//   CLK_HZ / BAUD   : default system clock and line rate
//   FRAME_CYCLES    : clocks per 10-bit frame at the default rate
//   TIMEOUT_DEFAULT : tx_done watchdog, one frame plus margin
//   feeder_state_t  : uart_tx_feeder FSM states
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned BYTE_WIDTH      = 8;
    localparam int unsigned CLK_HZ          = 100_000_000;
    localparam int unsigned BAUD            = 9600;
    localparam int unsigned CLKS_PER_BIT    = CLK_HZ / BAUD;
    localparam int unsigned FRAME_CYCLES    = CLKS_PER_BIT * 10;
    localparam int unsigned TIMEOUT_MARGIN  = 15_840;
    localparam int unsigned TIMEOUT_DEFAULT = FRAME_CYCLES + TIMEOUT_MARGIN;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        GAP       = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder_if
// Bundles the host write port, the uart_top launch interface and the error
// flags of uart_tx_feeder.
//   master : the feeder itself (drives full/level/data_in/tx_start/flags)
//   slave  : host + uart_top side (drives wr_en/wr_data/tx_done/err_clr)
// -----------------------------------------------------------------------------
interface uart_tx_feeder_if #(
    parameter int unsigned BYTE_WIDTH = uart_pkg::BYTE_WIDTH,
    parameter int unsigned DEPTH      = 16
);

    // host write port
    logic                   wr_en;
    logic [BYTE_WIDTH-1:0]  wr_data;
    logic                   full;
    logic [$clog2(DEPTH):0] level;

    // uart_top launch interface
    logic [BYTE_WIDTH-1:0]  data_in;
    logic                   tx_start;
    logic                   tx_done;

    // status / error
    logic                   busy;
    logic                   overflow;
    logic                   timeout_err;
    logic                   err_clr;

    modport master (
        input  wr_en,
        input  wr_data,
        input  tx_done,
        input  err_clr,
        output full,
        output level,
        output data_in,
        output tx_start,
        output busy,
        output overflow,
        output timeout_err
    );

    modport slave (
        output wr_en,
        output wr_data,
        output tx_done,
        output err_clr,
        input  full,
        input  level,
        input  data_in,
        input  tx_start,
        input  busy,
        input  overflow,
        input  timeout_err
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock show-ahead FIFO with extra-MSB pointers.
//   clk, arst_n : clock, asynchronous active-low reset
//   push, din   : write request (ignored while full) and write data
//   pop         : read request (ignored while empty)
//   dout        : current head entry, valid while !empty
//   full, empty : registered occupancy flags
//   level       : registered occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [BYTE_WIDTH-1:0]  din,
    output logic [BYTE_WIDTH-1:0]  dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [BYTE_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wptr_q;
    logic [PW-1:0]         rptr_q;
    logic [PW-1:0]         wptr_d;
    logic [PW-1:0]         rptr_d;
    logic                  do_push;
    logic                  do_pop;

    // qualified requests; full/empty are the pre-edge registered flags
    assign do_push = push && !full;
    assign do_pop  = pop  && !empty;

    // next pointers, natural wrap on the extra MSB
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PW'(1);
        end
    end

    // pointers and flags registered from the post-edge pointer values
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            level  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            full   <= (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
            empty  <= (wptr_d == rptr_d);
            level  <= wptr_d - rptr_d;
        end
    end

    // storage has no reset; contents are only observed behind valid pointers
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q[AW-1:0]] <= din;
        end
    end

    // show-ahead head
    assign dout = mem[rptr_q[AW-1:0]];

endmodule

// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder
// Transmit front end for uart_top: buffers host bytes in a FIFO and launches
// them one at a time, waiting for tx_done and an inter-frame gap between
// launches. Reports write overflow and a missing tx_done as sticky flags.
//   clk, arst_n       : clock, asynchronous active-low reset
//   bus.wr_en/wr_data : host write port; bus.full/level report occupancy
//   bus.data_in       : byte to uart_top, held for the whole frame
//   bus.tx_start      : one-cycle launch pulse to uart_top
//   bus.tx_done       : frame-complete from uart_top
//   bus.busy          : FSM not in IDLE
//   bus.overflow      : sticky, write attempted while full
//   bus.timeout_err   : sticky, tx_done missing for TIMEOUT_CYCLES
//   bus.err_clr       : clears both sticky flags, wins over a same-cycle set
// -----------------------------------------------------------------------------
module uart_tx_feeder #(
    parameter int unsigned BYTE_WIDTH     = uart_pkg::BYTE_WIDTH,
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned IFG_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = uart_pkg::TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              arst_n,
    uart_tx_feeder_if.master  bus
);

    import uart_pkg::*;

    localparam int unsigned LW      = $clog2(DEPTH) + 1;
    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > IFG_CYCLES) ? TIMEOUT_CYCLES : IFG_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    // elaboration-time parameter sanity
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_feeder: DEPTH must be a power of 2 and at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("uart_tx_feeder: TIMEOUT_CYCLES must be at least 1");
    end

    logic [BYTE_WIDTH-1:0] fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [LW-1:0]         fifo_level;
    logic                  pop_c;

    feeder_state_t         state_q;
    feeder_state_t         state_d;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic [BYTE_WIDTH-1:0] data_q;
    logic [BYTE_WIDTH-1:0] data_d;
    logic                  start_q;
    logic                  start_d;
    logic                  busy_q;
    logic                  busy_d;
    logic                  ovf_q;
    logic                  ovf_d;
    logic                  tmo_q;
    logic                  tmo_d;
    logic                  tmo_set_c;

    // byte buffer; push is gated by full inside the FIFO
    uart_sync_fifo #(
        .BYTE_WIDTH (BYTE_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .arst_n (arst_n),
        .push   (bus.wr_en),
        .pop    (pop_c),
        .din    (bus.wr_data),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    // state register and registered outputs
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
        end
    end

    // next state, counters, launch and error flags
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        start_d   = 1'b0;
        pop_c     = 1'b0;
        tmo_set_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    data_d  = fifo_dout;
                    start_d = 1'b1;
                    pop_c   = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end
            end

            WAIT_DONE: begin
                // start_q marks the launch cycle, where tx_done is not trusted
                if (bus.tx_done && !start_q) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_set_c = 1'b1;
                    cnt_d     = '0;
                    state_d   = GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            GAP: begin
                // GAP holds IFG_CYCLES+1 cycles so the next launch lands
                // IFG_CYCLES+2 edges after tx_done
                if (cnt_q == CW'(IFG_CYCLES)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        ovf_d  = bus.err_clr ? 1'b0 : (ovf_q | (bus.wr_en & fifo_full));
        tmo_d  = bus.err_clr ? 1'b0 : (tmo_q | tmo_set_c);
    end

    assign bus.full        = fifo_full;
    assign bus.level       = fifo_level;
    assign bus.data_in     = data_q;
    assign bus.tx_start    = start_q;
    assign bus.busy        = busy_q;
    assign bus.overflow    = ovf_q;
    assign bus.timeout_err = tmo_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_feeder
// Two feeder instances: u_dut0 (DEPTH 16, IFG 16) and u_dut1 (DEPTH 4, IFG 0,
// TIMEOUT 50), each driven by a small uart_top stand-in that answers every
// tx_start with tx_done a fixed number of cycles later.
// -----------------------------------------------------------------------------
module tb_uart_tx_feeder;

    localparam int unsigned BW   = 8;
    localparam int unsigned D0   = 16;
    localparam int unsigned IFG0 = 16;
    localparam int unsigned TMO0 = 300;
    localparam int unsigned D1   = 4;
    localparam int unsigned IFG1 = 0;
    localparam int unsigned TMO1 = 50;

    logic clk = 1'b0;
    logic arst0_n;
    logic arst1_n;

    always #5 clk = ~clk;

    uart_tx_feeder_if #(.BYTE_WIDTH(BW), .DEPTH(D0)) b0 ();
    uart_tx_feeder_if #(.BYTE_WIDTH(BW), .DEPTH(D1)) b1 ();

    uart_tx_feeder #(
        .BYTE_WIDTH(BW), .DEPTH(D0), .IFG_CYCLES(IFG0), .TIMEOUT_CYCLES(TMO0)
    ) u_dut0 (
        .clk    (clk),
        .arst_n (arst0_n),
        .bus    (b0)
    );

    uart_tx_feeder #(
        .BYTE_WIDTH(BW), .DEPTH(D1), .IFG_CYCLES(IFG1), .TIMEOUT_CYCLES(TMO1)
    ) u_dut1 (
        .clk    (clk),
        .arst_n (arst1_n),
        .bus    (b1)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // uart_top stand-in state, written only by the responder process
    int         frame0 = 40;
    int         frame1 = 6;
    bit         en0    = 1'b1;
    bit         en1    = 1'b1;
    int         cnt0, cnt1;
    int         last_done0 = -1, last_done1 = -1;
    int         last_start0 = 0, last_start1 = 0;
    int         starts0 = 0, starts1 = 0;
    int         maxlvl1 = 0;
    logic [7:0] rx0[$];
    logic [7:0] rx1[$];
    int         gap0[$];
    int         gap1[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wr0(input logic [7:0] d);
        b0.wr_en   = 1'b1;
        b0.wr_data = d;
        tick();
        b0.wr_en   = 1'b0;
    endtask

    task automatic wr1(input logic [7:0] d);
        b1.wr_en   = 1'b1;
        b1.wr_data = d;
        tick();
        b1.wr_en   = 1'b0;
    endtask

    // uart_top stand-in: samples tx_start and drives tx_done on the falling edge;
    // a gap is the negedge distance from a tx_done to the next tx_start
    initial begin
        b0.tx_done = 1'b0;
        b1.tx_done = 1'b0;
        cnt0 = 0;
        cnt1 = 0;
        forever begin
            @(negedge clk);
            cyc++;
            b0.tx_done = 1'b0;
            if (!arst0_n) begin
                cnt0       = 0;
                last_done0 = -1;
            end else if (b0.tx_start) begin
                rx0.push_back(b0.data_in);
                starts0++;
                if (last_done0 >= 0) gap0.push_back(cyc - last_done0);
                last_done0  = -1;
                last_start0 = cyc;
                cnt0        = frame0;
            end else if (cnt0 > 0) begin
                cnt0--;
                if (cnt0 == 0 && en0) begin
                    b0.tx_done = 1'b1;
                    last_done0 = cyc;
                end
            end

            b1.tx_done = 1'b0;
            if (32'(b1.level) > 32'(maxlvl1)) maxlvl1 = int'(b1.level);
            if (!arst1_n) begin
                cnt1       = 0;
                last_done1 = -1;
            end else if (b1.tx_start) begin
                rx1.push_back(b1.data_in);
                starts1++;
                if (last_done1 >= 0) gap1.push_back(cyc - last_done1);
                last_done1  = -1;
                last_start1 = cyc;
                cnt1        = frame1;
            end else if (cnt1 > 0) begin
                cnt1--;
                if (cnt1 == 0 && en1) begin
                    b1.tx_done = 1'b1;
                    last_done1 = cyc;
                end
            end
        end
    end

    initial begin
        int t_to;
        int s2;
        int st;

        arst0_n    = 1'b0;
        arst1_n    = 1'b0;
        b0.wr_en   = 1'b0;
        b0.wr_data = '0;
        b0.err_clr = 1'b0;
        b1.wr_en   = 1'b0;
        b1.wr_data = '0;
        b1.err_clr = 1'b0;
        repeat (3) tick();

        // reset values
        chk("rst_level",    32'(b0.level), 0);
        chk("rst_full",     32'(b0.full), 0);
        chk("rst_busy",     32'(b0.busy), 0);
        chk("rst_start",    32'(b0.tx_start), 0);
        chk("rst_data",     32'(b0.data_in), 0);
        chk("rst_ovf",      32'(b0.overflow), 0);
        chk("rst_tmo",      32'(b0.timeout_err), 0);
        chk("rst1_level",   32'(b1.level), 0);
        chk("rst1_busy",    32'(b1.busy), 0);
        arst0_n = 1'b1;
        arst1_n = 1'b1;
        repeat (2) tick();

        // single byte: accept edge N, tx_start in the cycle after N+1
        wr0(8'hA5);
        chk("t1_no_early_start", 32'(b0.tx_start), 0);
        chk("t1_level_accept",   32'(b0.level), 1);
        tick();
        chk("t1_start",  32'(b0.tx_start), 1);
        chk("t1_data",   32'(b0.data_in), 32'h A5);
        chk("t1_busy",   32'(b0.busy), 1);
        chk("t1_popped", 32'(b0.level), 0);

        // burst of 16 while the A5 frame is in flight
        for (int i = 0; i < 16; i++) begin
            wr0(8'(i + 1));
            if (i == 0) begin
                chk("t1_start_width", 32'(b0.tx_start), 0);
                chk("t1_data_hold",   32'(b0.data_in), 32'h A5);
            end
            if (i == 14) begin
                chk("t2_level_15",   32'(b0.level), 15);
                chk("t2_not_full15", 32'(b0.full), 0);
            end
        end
        chk("t2_full",     32'(b0.full), 1);
        chk("t2_level_16", 32'(b0.level), 16);
        chk("t2_no_ovf",   32'(b0.overflow), 0);
        wr0(8'hFF);
        chk("t2_ovf_set",   32'(b0.overflow), 1);
        chk("t2_ovf_level", 32'(b0.level), 16);
        b0.err_clr = 1'b1;
        tick();
        b0.err_clr = 1'b0;
        chk("t2_ovf_clr", 32'(b0.overflow), 0);

        // busy falls IFG+1 edges after the tx_done sample edge (18 negedges)
        for (int k = 0; k < 200 && b0.busy; k++) tick();
        chk("t1_wait_idle", 32'(b0.busy), 0);
        chk("t1_busy_fall", 32'(cyc - last_done0), 18);

        // one IDLE cycle with a full FIFO: pop and write on the same edge
        b0.wr_en   = 1'b1;
        b0.wr_data = 8'hEE;
        tick();
        b0.wr_en   = 1'b0;
        chk("t6_level",  32'(b0.level), 15);
        chk("t6_full",   32'(b0.full), 0);
        chk("t6_ovf",    32'(b0.overflow), 1);
        chk("t6_start",  32'(b0.tx_start), 1);
        chk("t6_data",   32'(b0.data_in), 32'h01);
        b0.err_clr = 1'b1;
        tick();
        b0.err_clr = 1'b0;
        chk("t6_ovf_clr", 32'(b0.overflow), 0);

        // drain and check order and launch spacing (IFG+2 edges = 19 negedges)
        for (int k = 0; k < 3000 && !(rx0.size() == 17 && !b0.busy); k++) tick();
        chk("t2_drained", 32'(rx0.size()), 17);
        for (int i = 0; i < rx0.size() && i < 17; i++)
            chk($sformatf("t2_rx%0d", i), 32'(rx0[i]), (i == 0) ? 32'h A5 : 32'(i));
        chk("t2_ngaps", 32'(gap0.size()), 16);
        for (int i = 0; i < gap0.size(); i++)
            chk($sformatf("t2_gap%0d", i), 32'(gap0[i]), 32'(IFG0 + 3));
        chk("t2_ovf_end", 32'(b0.overflow), 0);

        // wrap-around on DEPTH 4 with IFG 0
        for (int i = 0; i < 5; i++) wr1(8'(8'h30 + i));
        chk("t3_full_a",  32'(b1.full), 1);
        chk("t3_level_a", 32'(b1.level), 4);
        for (int k = 0; k < 500 && !(b1.busy == 1'b0 && b1.level == '0); k++) tick();
        chk("t3_idle_a", 32'(b1.busy), 0);
        for (int i = 0; i < 5; i++) wr1(8'(8'h35 + i));
        chk("t3_full_b",  32'(b1.full), 1);
        chk("t3_level_b", 32'(b1.level), 4);
        for (int k = 0; k < 500 && !(rx1.size() == 10 && !b1.busy); k++) tick();
        chk("t3_drained", 32'(rx1.size()), 10);
        for (int i = 0; i < rx1.size() && i < 10; i++)
            chk($sformatf("t3_rx%0d", i), 32'(rx1[i]), 32'(8'h30 + i));
        chk("t3_max_level", 32'(maxlvl1), 4);
        chk("t3_no_ovf",    32'(b1.overflow), 0);
        chk("t3_ngaps",     32'(gap1.size()), 9);
        // entry 4 spans the pause between the two bursts
        for (int i = 0; i < gap1.size() && i < 9; i++)
            if (i != 4) chk($sformatf("t3_gap%0d", i), 32'(gap1[i]), 32'(IFG1 + 3));

        // timeout: no tx_done, flag rises 50 edges after the launch edge
        en1 = 1'b0;
        wr1(8'h55);
        wr1(8'h66);
        for (int k = 0; k < 200 && !b1.timeout_err; k++) tick();
        chk("t4_tmo_set",     32'(b1.timeout_err), 1);
        chk("t4_tmo_latency", 32'(cyc - last_start1), 50);
        chk("t4_tmo_byte",    32'(rx1[rx1.size() - 1]), 32'h55);
        t_to = cyc;
        b1.err_clr = 1'b1;
        tick();
        b1.err_clr = 1'b0;
        chk("t4_tmo_clr", 32'(b1.timeout_err), 0);
        for (int k = 0; k < 20 && last_start1 <= t_to; k++) tick();
        chk("t4_resume",      32'(last_start1 - t_to), 2);
        chk("t4_resume_byte", 32'(rx1[rx1.size() - 1]), 32'h66);

        // err_clr on the edge of the second timeout wins; the event is lost
        s2 = last_start1;
        for (int k = 0; k < 100 && cyc < s2 + 49; k++) tick();
        chk("t4_align", 32'(cyc - s2), 49);
        b1.err_clr = 1'b1;
        tick();
        b1.err_clr = 1'b0;
        chk("t4_clr_priority", 32'(b1.timeout_err), 0);
        chk("t4_in_gap",       32'(b1.busy), 1);
        repeat (2) tick();
        chk("t4_tmo_stays",    32'(b1.timeout_err), 0);
        chk("t4_idle",         32'(b1.busy), 0);
        en1 = 1'b1;

        // reset during WAIT_DONE with bytes queued
        wr0(8'h11);
        wr0(8'h22);
        wr0(8'h33);
        chk("t5_level_pre", 32'(b0.level), 2);
        chk("t5_busy_pre",  32'(b0.busy), 1);
        chk("t5_data_pre",  32'(b0.data_in), 32'h11);
        arst0_n = 1'b0;
        #1;
        chk("t5_level", 32'(b0.level), 0);
        chk("t5_full",  32'(b0.full), 0);
        chk("t5_busy",  32'(b0.busy), 0);
        chk("t5_start", 32'(b0.tx_start), 0);
        chk("t5_data",  32'(b0.data_in), 0);
        tick();
        arst0_n = 1'b1;
        st = starts0;
        repeat (30) tick();
        chk("t5_no_start",   32'(starts0 - st), 0);
        chk("t5_level_post", 32'(b0.level), 0);
        chk("t5_busy_post",  32'(b0.busy), 0);
        wr0(8'h77);
        chk("t5_new_nostart", 32'(b0.tx_start), 0);
        tick();
        chk("t5_new_start", 32'(b0.tx_start), 1);
        chk("t5_new_data",  32'(b0.data_in), 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
